// File: rtl/hazard_detection_unit_mc.sv
// Load-use stall and branch/jump IF/ID flush controller with multi-cycle hold.
// Optional per-cycle stall/flush counters are compiled in with `define HAZARD_STATS_EN.
module hazard_detection_unit_mc #(
  parameter int REG_ADDR_W         = 4,
  parameter int LOAD_STALL         = 1,
  parameter int FLUSH_CYCLES       = 1,
  parameter int ZERO_REG_HARDWIRED = 1
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic                  IDEX_MemRead,
  input  logic                  IDEX_RegWrite,
  input  logic [REG_ADDR_W-1:0] IDEX_Rd,
  input  logic [REG_ADDR_W-1:0] IFID_Rs,
  input  logic [REG_ADDR_W-1:0] IFID_Rt,
  input  logic                  IFID_UsesRt,
  input  logic                  Branch,
  input  logic                  Jump,
  output logic                  ControllSignal,
  output logic                  FrezeIFID,
  output logic                  FrezePC,
  output logic                  FlushIFID,
  output logic                  Busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]           StallCount,
  output logic [15:0]           FlushCount
`endif
);

  typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

  localparam logic [3:0] STALL_LOAD = 4'(LOAD_STALL - 1);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       hz, br, zero_block;

  assign zero_block = (ZERO_REG_HARDWIRED != 0) && (IDEX_Rd == '0);
  assign hz = IDEX_MemRead && IDEX_RegWrite && !zero_block &&
              ((IFID_Rs == IDEX_Rd) || (IFID_UsesRt && (IFID_Rt == IDEX_Rd)));
  assign br = Branch | Jump;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    ControllSignal = 1'b1;
    FrezeIFID      = 1'b0;
    FrezePC        = 1'b0;
    FlushIFID      = 1'b0;
    state_nxt      = state;
    cnt_nxt        = cnt;
    if (br) begin
      // A resolved branch/jump wins over any stall or flush in progress.
      FlushIFID = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = FLUSH;
        cnt_nxt   = FLUSH_LOAD;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (hz) begin
            ControllSignal = 1'b0;
            FrezeIFID      = 1'b1;
            FrezePC        = 1'b1;
            if (LOAD_STALL > 1) begin
              state_nxt = STALL;
              cnt_nxt   = STALL_LOAD;
            end
          end
        end
        STALL, FLUSH: begin
          if (state == STALL) begin
            ControllSignal = 1'b0;
            FrezeIFID      = 1'b1;
            FrezePC        = 1'b1;
          end else begin
            FlushIFID = 1'b1;
          end
          if (cnt == 4'd1) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
    // Outputs are forced to their idle values for as long as reset is held.
    if (!rest) begin
      ControllSignal = 1'b1;
      FrezeIFID      = 1'b0;
      FrezePC        = 1'b0;
      FlushIFID      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign Busy = (state != IDLE);

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (FrezePC && (StallCount != 16'hFFFF)) StallCount <= StallCount + 16'd1;
      if (FlushIFID && (FlushCount != 16'hFFFF)) FlushCount <= FlushCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_detection_unit_mc.sv
// Bench for hazard_detection_unit_mc: three parameter sets share one stimulus
// stream and are checked against a remaining-cycles reference model.
module tb_hazard_detection_unit_mc;

  localparam int NCFG = 3;
  localparam int LS_P [NCFG] = '{3, 1, 4};
  localparam int FC_P [NCFG] = '{2, 1, 3};
  localparam int Z_P  [NCFG] = '{1, 0, 1};

  logic       clk = 1'b0;
  logic       rest;
  logic       mem_read, reg_write, uses_rt, branch, jump;
  logic [3:0] rd, rs, rt;

  logic [4:0]  obs [NCFG];   // {ControllSignal, FrezeIFID, FrezePC, FlushIFID, Busy}
  logic [15:0] sc  [NCFG];
  logic [15:0] fcn [NCFG];

  int tests = 0;
  int fails = 0;

  int stall_left [NCFG];
  int flush_left [NCFG];
  int exp_sc     [NCFG];
  int exp_fc     [NCFG];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    logic cs, fi, fp, fl, bz;
    hazard_detection_unit_mc #(
      .REG_ADDR_W(4), .LOAD_STALL(LS_P[g]), .FLUSH_CYCLES(FC_P[g]),
      .ZERO_REG_HARDWIRED(Z_P[g])
    ) u_dut (
      .clk(clk), .rest(rest),
      .IDEX_MemRead(mem_read), .IDEX_RegWrite(reg_write), .IDEX_Rd(rd),
      .IFID_Rs(rs), .IFID_Rt(rt), .IFID_UsesRt(uses_rt),
      .Branch(branch), .Jump(jump),
      .ControllSignal(cs), .FrezeIFID(fi), .FrezePC(fp), .FlushIFID(fl), .Busy(bz)
`ifdef HAZARD_STATS_EN
      , .StallCount(sc[g]), .FlushCount(fcn[g])
`endif
    );
    assign obs[g] = {cs, fi, fp, fl, bz};
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_hz(int g);
    return mem_read && reg_write && !(Z_P[g] != 0 && rd == 4'd0) &&
           (rs == rd || (uses_rt && rt == rd));
  endfunction

  // Expected outputs for the current cycle from the remaining-cycle counts.
  function automatic logic [4:0] model_out(int g);
    logic busy;
    busy = (stall_left[g] > 0) || (flush_left[g] > 0);
    if (branch || jump || flush_left[g] > 0) return {4'b1001, busy};
    if (stall_left[g] > 0 || model_hz(g))    return {4'b0110, busy};
    return {4'b1000, busy};
  endfunction

  task automatic model_reset();
    for (int g = 0; g < NCFG; g++) begin
      stall_left[g] = 0; flush_left[g] = 0; exp_sc[g] = 0; exp_fc[g] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("%s_cfg%0d_outs", tag, g), 16'(obs[g]), 16'(model_out(g)));
      check($sformatf("%s_cfg%0d_excl", tag, g), 16'(obs[g][2] & obs[g][1]), 16'd0);
`ifdef HAZARD_STATS_EN
      check($sformatf("%s_cfg%0d_scnt", tag, g), sc[g], 16'(exp_sc[g]));
      check($sformatf("%s_cfg%0d_fcnt", tag, g), fcn[g], 16'(exp_fc[g]));
`endif
    end
  endtask

  task automatic cycle(input string tag, input logic mr, input logic rw, input logic [3:0] d,
                       input logic [3:0] s, input logic [3:0] t, input logic ur,
                       input logic b, input logic j);
    logic [4:0] e [NCFG];
    logic       h [NCFG];
    mem_read = mr; reg_write = rw; rd = d; rs = s; rt = t; uses_rt = ur;
    branch = b; jump = j;
    #2;
    check_all(tag);
    for (int g = 0; g < NCFG; g++) begin
      e[g] = model_out(g);
      h[g] = model_hz(g);
    end
    @(posedge clk);
    for (int g = 0; g < NCFG; g++) begin
      if (e[g][2] && exp_sc[g] < 16'hFFFF) exp_sc[g]++;
      if (e[g][1] && exp_fc[g] < 16'hFFFF) exp_fc[g]++;
      if (b || j) begin
        flush_left[g] = FC_P[g] - 1;
        stall_left[g] = 0;
      end else if (flush_left[g] > 0) flush_left[g]--;
      else if (stall_left[g] > 0) stall_left[g]--;
      else if (h[g]) stall_left[g] = LS_P[g] - 1;
    end
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle("idle", 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0);
  endtask

  initial begin
    rest = 1'b0;
    mem_read = 1; reg_write = 1; rd = 4'd5; rs = 4'd5; rt = 4'd0; uses_rt = 0;
    branch = 0; jump = 0;
    model_reset();
    #1;
    for (int g = 0; g < NCFG; g++)
      check($sformatf("reset_cfg%0d", g), 16'(obs[g]), 16'b10000);
    @(posedge clk); #3;
    rest = 1'b1;
    #1;

    // Load-use on Rs for one cycle, then the load goes away.
    cycle("lu_rs", 1, 1, 4'd5, 4'd5, 4'd2, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle("lu_tail", 0, 1, 4'd5, 4'd5, 4'd2, 0, 0, 0);

    // Rd==0 on Rt: stalls only where the zero register is not hardwired.
    cycle("zero_rt", 1, 1, 4'd0, 4'd7, 4'd0, 1, 0, 0);
    idle_cycles(4);

    // Hazard and branch together: flush only.
    cycle("hz_br", 1, 1, 4'd3, 4'd3, 4'd3, 1, 1, 0);
    idle_cycles(4);

    // Jump in the second stall cycle aborts the stall.
    cycle("lu_j0", 1, 1, 4'd6, 4'd1, 4'd6, 1, 0, 0);
    cycle("lu_j1", 0, 0, 4'd6, 4'd1, 4'd6, 1, 0, 1);
    idle_cycles(4);

    // Back-to-back hazards restart a full stall sequence.
    for (int i = 0; i < 6; i++) cycle("b2b", 1, 1, 4'd4, 4'd4, 4'd0, 0, 0, 0);
    idle_cycles(4);

    // Asynchronous reset in the middle of a stall.
    cycle("rst_pre", 1, 1, 4'd9, 4'd9, 4'd0, 0, 0, 0);
    cycle("rst_mid", 1, 1, 4'd9, 4'd9, 4'd0, 0, 0, 0);
    #3;
    rest = 1'b0;
    #1;
    model_reset();
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("async_rst_cfg%0d", g), 16'(obs[g]), 16'b10000);
`ifdef HAZARD_STATS_EN
      check($sformatf("async_rst_scnt%0d", g), sc[g], 16'd0);
`endif
    end
    #1;
    rest = 1'b1;
    idle_cycles(2);

    // Randomized traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 11) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit_mc.md
Name: hazard_detection_unit_mc

Overview:
- Parametrised, clocked successor to the pipeline's load-use hazard detector.
- Detects load-use hazards between ID/EX and IF/ID. Holds a stall for a configurable number of cycles to support multi-cycle data memory.
- Generates a multi-cycle IF/ID flush on taken branches and jumps.
- Sits beside the ID stage. Drives the control-mux bubble select, the PC/IFID freeze signals and the IFID flush.

Parameters:
- REG_ADDR_W, 4: width of register specifiers.
- LOAD_STALL, 1: stall cycles per load-use hazard. Legal range 1..15.
- FLUSH_CYCLES, 1: cycles FlushIFID stays high per branch/jump. Legal range 1..15.
- ZERO_REG_HARDWIRED, 1: if 1, Rd==0 never causes a hazard.

Ports:
- clk  in  1  rising-edge clock
- rest  in  1  asynchronous, active-low reset
- IDEX_MemRead  in  1  instruction in EX is a load
- IDEX_RegWrite  in  1  instruction in EX writes a register
- IDEX_Rd  in  REG_ADDR_W  destination register of EX instruction
- IFID_Rs  in  REG_ADDR_W  source 1 of ID instruction
- IFID_Rt  in  REG_ADDR_W  source 2 of ID instruction
- IFID_UsesRt  in  1  ID instruction actually reads Rt
- Branch  in  1  taken branch resolved this cycle
- Jump  in  1  jump resolved this cycle
- ControllSignal  out  1  1 = pass control, 0 = insert bubble
- FrezeIFID  out  1  hold IF/ID register
- FrezePC  out  1  hold PC
- FlushIFID  out  1  clear IF/ID register
- Busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rest==0, async):
  - FSM enters IDLE and counter clears to 0.
  - ControllSignal=1, FrezeIFID=0, FrezePC=0, FlushIFID=0, Busy=0, immediately and independent of clk.
- hz (combinational) = IDEX_MemRead & IDEX_RegWrite & (IFID_Rs==IDEX_Rd | (IFID_UsesRt & IFID_Rt==IDEX_Rd)) & ~(ZERO_REG_HARDWIRED & IDEX_Rd==0).
- br = Branch | Jump.
- FSM states are IDLE, STALL and FLUSH. The down-counter cnt is 4 bits.
- IDLE:
  - If br: FlushIFID=1 in the same cycle (combinational). If FLUSH_CYCLES>1, at the edge go to FLUSH with cnt=FLUSH_CYCLES-1. hz is ignored; no stall.
  - Else if hz: ControllSignal=0, FrezeIFID=1, FrezePC=1 in the same cycle. If LOAD_STALL>1, go to STALL with cnt=LOAD_STALL-1.
  - Otherwise all outputs hold their reset values.
- STALL:
  - ControllSignal=0, FrezeIFID=1, FrezePC=1.
  - cnt decrements each edge. When cnt==1 at the edge, go to IDLE.
  - Total stall per hazard = LOAD_STALL cycles.
- FLUSH:
  - FlushIFID=1; freeze outputs are 0 and ControllSignal=1. hz is suppressed.
  - cnt decrements each edge. When cnt==1 at the edge, go to IDLE.
- Branch/jump priority:
  - br in STALL or FLUSH aborts the current operation. FlushIFID=1 in the same cycle.
  - Freezes drop and ControllSignal=1 in that cycle.
  - Reload cnt=FLUSH_CYCLES-1 and go to FLUSH, or go to IDLE if FLUSH_CYCLES==1.
- Back-to-back: returning to IDLE re-evaluates hz in the following cycle. A new hazard restarts a full LOAD_STALL sequence.
- Freeze and flush are never asserted in the same cycle.
- Busy = (state != IDLE).

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - Adds output StallCount [15:0], incremented on every cycle FrezePC==1.
  - Adds output FlushCount [15:0], incremented on every cycle FlushIFID==1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- LOAD_STALL=1, IDEX_MemRead=1, IDEX_RegWrite=1, IDEX_Rd=5, IFID_Rs=5 -> stall outputs asserted that cycle only. Busy stays 0.
- LOAD_STALL=3, same hazard, held one cycle then IDEX_MemRead=0 -> FrezePC=1, FrezeIFID=1, ControllSignal=0 for exactly 3 cycles, then all outputs at reset values.
- IDEX_Rd=0, IFID_Rt=0, IFID_UsesRt=1, ZERO_REG_HARDWIRED=1 -> no stall. Same stimulus with parameter 0 -> stall.
- FLUSH_CYCLES=2, hazard and Branch=1 in the same cycle -> FlushIFID=1 for 2 cycles. No freeze in any cycle.
- LOAD_STALL=4, Jump=1 in the 2nd stall cycle -> freezes drop in that cycle and FlushIFID=1. Then IDLE.
- Drive rest=0 mid-STALL between clock edges -> outputs return to reset values immediately. With HAZARD_STATS_EN, StallCount=0.
